banked_ram: RTL and testbench

Parametrised, banked, single-port synchronous RAM for the Lab 5 datapath. It replaces the fixed 256 x 32 four-bank store built from 64 x 8 SmallRam slices. Bank select is decoded from the upper address bits, as in the earlier design. New in this block: parametrised width, depth and bank count, per-byte write enables, a registered read port with a valid strobe, and a post-reset clear sweep that zeroes every location.

---
 rtl/banked_ram.sv | 107 ++++++++++
 tb/tb_banked_ram.sv | 139 +++++++++++++
 2 files changed

// File: rtl/banked_ram.sv
// rtl/banked_ram.sv - banked single-port RAM with byte enables, registered read port, optional post-reset clear sweep
// Optional clear sweep is built only when BANKED_RAM_CLEAR_EN is defined.
module banked_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int BANK_BITS = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                en,
  input  logic                WR,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W-1:0]   Din,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic [DATA_W-1:0]   Dout,
  output logic                Valid,
  output logic                Busy,
  output logic                Reject
);
  localparam int NBANK = 2**BANK_BITS;
  localparam int ROW_W = ADDR_W - BANK_BITS;
  localparam int ROWS  = 2**ROW_W;
  localparam int NBYTE = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [NBANK][ROWS];
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
  logic              reject_q;

  logic [BANK_BITS-1:0] bank;
  logic [ROW_W-1:0]     row;
  logic                 busy;
  logic                 accept;
  logic                 clr_we;
  logic [ROW_W-1:0]     clr_row;

  assign bank   = Address[ADDR_W-1 -: BANK_BITS];
  assign row    = Address[ROW_W-1:0];
  assign accept = en && !busy;

`ifdef BANKED_RAM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ROW_W'(ROWS - 1)) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  assign busy    = (state_q == S_CLEAR);
  assign clr_row = cnt_q;
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_row = '0;
`endif

  // Nothing is written during a reset cycle, so rows already swept stay cleared.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      if (clr_we) begin
        for (int b = 0; b < NBANK; b++) mem_q[b][clr_row] <= '0;
      end else if (accept && WR) begin
        for (int i = 0; i < NBYTE; i++)
          if (ByteEn[i]) mem_q[bank][row][8*i +: 8] <= Din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      dout_q   <= '0;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      valid_q  <= accept && !WR;
      reject_q <= en && busy;
      if (accept && !WR) dout_q <= mem_q[bank][row];
    end
  end

  assign Dout   = dout_q;
  assign Valid  = valid_q;
  assign Busy   = busy;
  assign Reject = reject_q;
endmodule

// File: tb/tb_banked_ram.sv
// tb/tb_banked_ram.sv - randomized self-checking bench for banked_ram against a word-array reference model
module tb_banked_ram;
  localparam int ROWS = 64;

  logic        Clk = 1'b0;
  logic        Rst_n, en, WR;
  logic [7:0]  Address;
  logic [31:0] Din, Dout;
  logic [3:0]  ByteEn;
  logic        Valid, Busy, Reject;

  always #5 Clk = ~Clk;

  banked_ram dut (
    .Clk(Clk), .Rst_n(Rst_n), .en(en), .WR(WR), .Address(Address),
    .Din(Din), .ByteEn(ByteEn), .Dout(Dout), .Valid(Valid),
    .Busy(Busy), .Reject(Reject)
  );

  logic [31:0] mem_m [256];
  logic [31:0] exp_dout;
  int          busy_left;
  int          total = 0;
  int          bad   = 0;
`ifdef BANKED_RAM_CLEAR_EN
  localparam bit CLEAR_ON = 1'b1;
`else
  localparam bit CLEAR_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle with the given request; model advances, then outputs are checked.
  task automatic cyc(input logic e, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    logic acc;
    int   r;
    en = e; WR = w; Address = a; Din = d; ByteEn = be;
    acc = e && (busy_left == 0);
    @(posedge Clk); #1;
    if (busy_left > 0) begin
      r = ROWS - busy_left;
      for (int b = 0; b < 4; b++) mem_m[b*ROWS + r] = 32'h0;
      busy_left--;
    end
    if (acc && w)
      for (int i = 0; i < 4; i++) if (be[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
    if (acc && !w) exp_dout = mem_m[a];
    check("valid",  {31'b0, Valid},  {31'b0, acc && !w});
    check("reject", {31'b0, Reject}, {31'b0, e && !acc});
    check("dout",   Dout, exp_dout);
    check("busy",   {31'b0, Busy},   {31'b0, busy_left > 0});
    en = 1'b0;
  endtask

  task automatic do_reset(input logic e);
    Rst_n = 1'b0; en = e; WR = 1'b1; Address = 8'h10; Din = 32'h1234_5678; ByteEn = 4'hF;
    @(posedge Clk); #1;
    exp_dout  = 32'h0;
    busy_left = CLEAR_ON ? ROWS : 0;
    check("rst_dout",   Dout, 32'h0);
    check("rst_valid",  {31'b0, Valid},  32'h0);
    check("rst_reject", {31'b0, Reject}, 32'h0);
    check("rst_busy",   {31'b0, Busy},   {31'b0, CLEAR_ON});
    Rst_n = 1'b1; en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    cyc(1'b1, 1'b1, a, d, be);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  initial begin
    logic [7:0] edges [8];
    edges = '{8'h00, 8'h3F, 8'h40, 8'h7F, 8'h80, 8'hBF, 8'hC0, 8'hFF};
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    Rst_n = 1'b0; en = 1'b0; WR = 1'b0; Address = '0; Din = '0; ByteEn = '0;
    exp_dout = 32'h0; busy_left = 0;
    @(negedge Clk);
    do_reset(1'b1);

    if (CLEAR_ON) begin
      // Sweep with a write dropped at sweep cycle 5; cyc checks Busy each cycle.
      for (int c = 0; c < ROWS; c++) begin
        if (c == 5) cyc(1'b1, 1'b1, 8'h10, 32'hCAFE_F00D, 4'hF);
        else        cyc(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      end
      for (int a = 0; a < 256; a++) rd(8'(a));
    end else begin
      wr(8'hC3, 32'hDEAD_BEEF, 4'hF);
      rd(8'hC3);
      check("macro_off_c3", Dout, 32'hDEAD_BEEF);
    end

    // Fill every address so later reads are defined without a sweep.
    for (int a = 0; a < 256; a++) wr(8'(a), $urandom, 4'hF);

    foreach (edges[k]) wr(edges[k], 32'hA5A5_0000 + 32'(edges[k]), 4'hF);
    foreach (edges[k]) begin
      rd(edges[k]);
      check("bank_edge", Dout, 32'hA5A5_0000 + 32'(edges[k]));
    end

    wr(8'h45, 32'h1122_3344, 4'hF);
    wr(8'h45, 32'hFFFF_FFFF, 4'b0101);
    rd(8'h45);
    check("byte_en", Dout, 32'h11FF_33FF);
    wr(8'h45, 32'h0000_0000, 4'h0);
    rd(8'h45);
    check("byte_en_zero", Dout, 32'h11FF_33FF);

    for (int n = 0; n < 600; n++)
      cyc(1'($urandom), 1'($urandom), 8'($urandom), $urandom, 4'($urandom));

    if (CLEAR_ON) begin
      do_reset(1'b0);
      for (int c = 0; c < 30; c++) cyc(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      do_reset(1'b1);
      for (int c = 0; c < ROWS; c++)
        cyc(1'($urandom), 1'($urandom), 8'($urandom), $urandom, 4'($urandom));
      check("sweep_done_busy", {31'b0, Busy}, 32'h0);
      rd(8'h10);
      check("cleared_0x10", Dout, 32'h0);
      for (int n = 0; n < 100; n++) rd(8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
